// File: rtl/bram_bus_responder.sv
// Block-RAM backed responder for the local memory bus: bursts of 16-bit words, one per clock.
// Optional RESP_WAIT_STATES_EN inserts WAIT_CYCLES of latency before every burst.
module bram_bus_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned BUS_WORDS   = 128,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [23:0]            addr,
  input  logic [16*BUS_WORDS-1:0] data_write,
  input  logic [8:0]             data_write_size,
  input  logic [8:0]             data_read_size,
  input  logic                   request,
  input  logic                   n_write_enable,
  output logic [16*BUS_WORDS-1:0] data_read,
  output logic                   data_ready,
  output logic                   save_ready,
  output logic                   busy
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = $clog2(BUS_WORDS + 1);
`ifdef RESP_WAIT_STATES_EN
  localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef RESP_WAIT_STATES_EN
    S_WAIT,
`endif
    S_READ,
    S_WRITE,
    S_DONE,
    S_HOLD
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [CNT_W-1:0]   last;
  logic [ADDR_W-1:0]  base;
  logic               is_read;
  logic               busy_d, data_ready_d, save_ready_d;
  logic               accept_c, mem_we_c, cap_en_c;
  logic [ADDR_W-1:0]  mem_addr_c;
  logic [CNT_W-1:0]   cap_idx_c;
  logic [CNT_W-1:0]   req_last_c;
  logic [8:0]         size_sel_c;
  logic [WORD_W-1:0]  wdata_c;
  logic [WORD_W-1:0]  rdata;
  logic [WORD_W-1:0]  mem [DEPTH];
  logic               unused_addr_hi_c;
`ifdef RESP_WAIT_STATES_EN
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_d;
`endif

  // Upper address bits alias onto the RAM.
  assign unused_addr_hi_c = ^addr[23:ADDR_W];

  // Burst length minus one, clamped to the bus width.
  assign size_sel_c = n_write_enable ? data_read_size : data_write_size;
  assign req_last_c = (32'(size_sel_c) >= BUS_WORDS) ? CNT_W'(BUS_WORDS - 1) : CNT_W'(size_sel_c);
  assign wdata_c    = data_write[{cnt, 4'h0} +: WORD_W];

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    busy_d       = busy;
    data_ready_d = 1'b0;
    save_ready_d = 1'b0;
    accept_c     = 1'b0;
    mem_we_c     = 1'b0;
    cap_en_c     = 1'b0;
    mem_addr_c   = base + ADDR_W'(cnt);
    cap_idx_c    = cnt - CNT_W'(1);
`ifdef RESP_WAIT_STATES_EN
    wait_cnt_d   = wait_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (request) begin
          accept_c = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
`ifdef RESP_WAIT_STATES_EN
          wait_cnt_d = '0;
          state_d    = S_WAIT;
`else
          state_d  = n_write_enable ? S_READ : S_WRITE;
`endif
        end
      end
`ifdef RESP_WAIT_STATES_EN
      S_WAIT: begin
        if (wait_cnt == WAIT_W'(WAIT_CYCLES - 1)) state_d = is_read ? S_READ : S_WRITE;
        else wait_cnt_d = wait_cnt + WAIT_W'(1);
      end
`endif
      // Address issue leads capture by one clock (RAM read latency).
      S_READ: begin
        cnt_d    = cnt + CNT_W'(1);
        cap_en_c = (cnt != '0);
        if (cnt == last + CNT_W'(1)) begin
          data_ready_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_WRITE: begin
        mem_we_c = 1'b1;
        cnt_d    = cnt + CNT_W'(1);
        if (cnt == last) begin
          save_ready_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE, S_HOLD: begin
        if (!request) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      data_ready <= 1'b0;
      save_ready <= 1'b0;
`ifdef RESP_WAIT_STATES_EN
      wait_cnt   <= '0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      busy       <= busy_d;
      data_ready <= data_ready_d;
      save_ready <= save_ready_d;
`ifdef RESP_WAIT_STATES_EN
      wait_cnt   <= wait_cnt_d;
`endif
    end
  end

  // Transaction parameters captured at acceptance only.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      base    <= '0;
      last    <= '0;
      is_read <= 1'b0;
    end else if (accept_c) begin
      base    <= addr[ADDR_W-1:0];
      last    <= req_last_c;
      is_read <= n_write_enable;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) data_read <= '0;
    else if (cap_en_c) data_read[{cap_idx_c, 4'h0} +: WORD_W] <= rdata;
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_addr_c] <= wdata_c;
    rdata <= mem[mem_addr_c];
  end

endmodule

// File: tb/tb_bram_bus_responder.sv
// Randomized scoreboard bench for bram_bus_responder against an array-based memory model.
module tb_bram_bus_responder;

  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned BUS_WORDS   = 128;
  localparam int unsigned WAIT_CYCLES = 4;
  localparam int unsigned BUS_W       = 16 * BUS_WORDS;
  localparam int unsigned DEPTH       = 1 << ADDR_W;
`ifdef RESP_WAIT_STATES_EN
  localparam int EXTRA = WAIT_CYCLES;
`else
  localparam int EXTRA = 0;
`endif

  logic             clk = 1'b0;
  logic             nreset;
  logic [23:0]      addr;
  logic [BUS_W-1:0] data_write;
  logic [8:0]       data_write_size, data_read_size;
  logic             request, n_write_enable;
  logic [BUS_W-1:0] data_read;
  logic             data_ready, save_ready, busy;

  bram_bus_responder #(.ADDR_W(ADDR_W), .BUS_WORDS(BUS_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .nreset(nreset), .addr(addr), .data_write(data_write),
    .data_write_size(data_write_size), .data_read_size(data_read_size),
    .request(request), .n_write_enable(n_write_enable), .data_read(data_read),
    .data_ready(data_ready), .save_ready(save_ready), .busy(busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit               is_read;
    int               cyc;
    logic [BUS_W-1:0] data;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  logic [15:0]      mdl [DEPTH];
  logic [BUS_W-1:0] exp_rd = '0;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chkv(input string nm, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int k = BUS_WORDS - 1; k >= 0; k--)
      if (act[k*16 +: 16] !== exp[k*16 +: 16]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s slice %0d actual=%h expected=%h at cycle %0d",
               nm, bad, act[bad*16 +: 16], exp[bad*16 +: 16], cyc);
    end
  endtask

  function automatic logic [BUS_W-1:0] rand_pl();
    logic [BUS_W-1:0] v;
    for (int k = 0; k < BUS_WORDS; k++) v[k*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  // Monitor: every completion pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (nreset && (data_ready || save_ready)) begin
      if (data_ready && save_ready) begin
        checks++; errors++;
        $display("FAIL both_pulses actual=11 expected=one-hot at cycle %0d", cyc);
      end
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse ready=%0b save=%0b expected=none at cycle %0d",
                 data_ready, save_ready, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", 32'(data_ready), 32'(mon_e.is_read));
        chk("pulse_cycle", cyc, mon_e.cyc);
        if (mon_e.is_read) chkv("read_data", data_read, mon_e.data);
      end
    end
  end

  // Issue one transaction from a negedge with the DUT idle; returns at a negedge with busy low.
  task automatic txn(input bit rd, input logic [23:0] a, input logic [8:0] sz,
                     input logic [BUS_W-1:0] pl, input int hold, input bit early);
    int w, acc, n;
    int unsigned b;
    exp_t e;
    chk("idle_before", 32'(busy), 32'd0);
    n_write_enable  = rd;
    addr            = a;
    data_read_size  = rd ? sz : 9'($urandom);
    data_write_size = rd ? 9'($urandom) : sz;
    data_write      = pl;
    request         = 1'b1;
    acc = cyc + 1;
    w   = (sz >= 9'(BUS_WORDS)) ? BUS_WORDS : int'(sz) + 1;
    b   = a % DEPTH;
    e.is_read = rd;
    if (rd) begin
      for (int k = 0; k < w; k++) exp_rd[k*16 +: 16] = mdl[(b + k) % DEPTH];
      e.cyc  = acc + w + 1 + EXTRA;
      e.data = exp_rd;
    end else begin
      for (int k = 0; k < w; k++) mdl[(b + k) % DEPTH] = pl[k*16 +: 16];
      e.cyc  = acc + w + EXTRA;
      e.data = '0;
    end
    sb.push_back(e);
    @(negedge clk);
    chk("busy_after_accept", 32'(busy), 32'd1);
    addr            = 24'($urandom);
    data_read_size  = 9'($urandom);
    data_write_size = 9'($urandom);
    n_write_enable  = 1'($urandom);
    if (early) request = 1'b0;
    n = 0;
    while (!(data_ready || save_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL pulse_timeout actual=none expected=pulse at cycle %0d", cyc);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("busy_hold", 32'(busy), 32'd1);
    end
    request = 1'b0;
    @(negedge clk);
    chk("busy_release", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [BUS_W-1:0] pl;
    int acc;
    nreset = 1'b0; request = 1'b0; n_write_enable = 1'b1; addr = '0;
    data_write = '0; data_write_size = '0; data_read_size = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    chk("rst_save_ready", 32'(save_ready), 32'd0);
    chkv("rst_data_read", data_read, exp_rd);
    nreset = 1'b1;
    @(negedge clk);

    // Fill the whole RAM so every later read has a known expectation.
    for (int i = 0; i < int'(DEPTH / BUS_WORDS); i++)
      txn(1'b0, 24'(i * BUS_WORDS), 9'(BUS_WORDS - 1), rand_pl(), 0, 1'b0);

    // Write then read four words.
    pl = rand_pl();
    pl[15:0] = 16'h1111; pl[31:16] = 16'h2222; pl[47:32] = 16'h3333; pl[63:48] = 16'h4444;
    txn(1'b0, 24'h000010, 9'd3, pl, 0, 1'b0);
    txn(1'b1, 24'h000010, 9'd3, rand_pl(), 0, 1'b0);

    // Wrap at the top of RAM and upper-address aliasing.
    pl = rand_pl();
    pl[15:0] = 16'hAAAA; pl[31:16] = 16'hBBBB;
    txn(1'b0, 24'h000FFF, 9'd1, pl, 0, 1'b0);
    txn(1'b1, 24'h000FFE, 9'd2, rand_pl(), 0, 1'b0);
    txn(1'b1, 24'h000000, 9'd0, rand_pl(), 0, 1'b0);
    txn(1'b1, 24'h001000, 9'd0, rand_pl(), 0, 1'b0);

    // Request held past completion, then immediate re-request.
    txn(1'b0, 24'h000123, 9'd2, rand_pl(), 10, 1'b0);
    txn(1'b1, 24'h000123, 9'd2, rand_pl(), 0, 1'b0);

    // Size clamp then single-word read preserving the rest.
    txn(1'b1, 24'h000800, 9'h1FF, rand_pl(), 0, 1'b0);
    txn(1'b1, 24'h000040, 9'd0, rand_pl(), 0, 1'b0);
    txn(1'b1, 24'h000F90, 9'd200, rand_pl(), 0, 1'b0);

    // Reset during word 2 of an eight-word write.
    pl = rand_pl();
    n_write_enable = 1'b0; addr = 24'h000300; data_write_size = 9'd7;
    data_write = pl; request = 1'b1;
    acc = cyc + 1;
    while (cyc < acc + 2 + EXTRA) @(negedge clk);
    nreset = 1'b0; request = 1'b0;
    mdl[12'h300] = pl[15:0];
    mdl[12'h301] = pl[31:16];
    exp_rd = '0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_save_ready", 32'(save_ready), 32'd0);
    chkv("midrst_data_read", data_read, exp_rd);
    @(negedge clk);
    nreset = 1'b1;
    repeat (12) @(negedge clk);
    txn(1'b1, 24'h000300, 9'd7, rand_pl(), 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      bit rd, early;
      logic [8:0] sz;
      int hold;
      rd    = 1'($urandom);
      early = 1'($urandom);
      hold  = early ? 0 : int'($urandom_range(0, 3));
      sz    = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
      txn(rd, 24'($urandom), sz, rand_pl(), hold, early);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
